bcd_mul_arb4: RTL

Four-requester round-robin arbiter and two-stage pipeline around one shared 4x4 digit multiplier array. Up to four client blocks can use a single multiplier instead of each instantiating its own. The block:
- grants one requester per cycle and captures its operands;
- forms the product in the next stage;
- presents a registered result tagged with the requester ID, under valid/ready backpressure.

---
 rtl/bcd_mul_arb4_if.sv | 23 ++
 rtl/bcd_mul_arb4.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bcd_mul_arb4_if.sv
// Request/grant and result bus of the shared digit multiplier.
// master = client side (requesters and result consumer), slave = the block.
interface bcd_mul_arb4_if;
  logic [3:0] req;
  logic [3:0] a0, a1, a2, a3;
  logic [3:0] b0, b1, b2, b3;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [1:0] out_id;
  logic       out_err;

  modport master (
    output req, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    input  gnt, out_valid, out_y, out_id, out_err
  );

  modport slave (
    input  req, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    output gnt, out_valid, out_y, out_id, out_err
  );
endinterface

// File: rtl/bcd_mul_arb4.sv
// Four-requester round-robin arbiter in front of one shared 4x4 multiplier.
// S1 captures the granted operands, S2 registers the 8-bit product, tagged
// with the requester id, under valid/ready backpressure.
// Optional feature: define BCD_MUL_ARB_DIGIT_CHECK_EN to flag operands > 9
// as invalid decimal digits (product forced to 0, out_err set).
module bcd_mul_arb4 (
  input  logic          clk,
  input  logic          reset,
  bcd_mul_arb4_if.slave bus
);

  // Stage 1: captured operands
  logic       r_s1_valid;
  logic [3:0] r_s1_a;
  logic [3:0] r_s1_b;
  logic [1:0] r_s1_id;
  // Round-robin pointer: last granted requester
  logic [1:0] r_ptr;
  // Stage 2: output register
  logic       r_out_valid;
  logic [7:0] r_out_y;
  logic [1:0] r_out_id;
  logic       r_out_err;

  logic       w_adv2;
  logic       w_acc1;
  logic       w_any;
  logic [1:0] w_win;
  logic [1:0] w_scan;
  logic [3:0] w_gnt;
  logic [3:0] w_sel_a;
  logic [3:0] w_sel_b;
  logic [7:0] w_prod;
  logic [7:0] w_y;
  logic       w_bad;

  assign w_adv2 = !r_out_valid || bus.out_ready;
  assign w_acc1 = !r_s1_valid || w_adv2;

  // Round-robin search: scan ptr+4 (= ptr, lowest priority) down to ptr+1 so
  // the nearest requester above ptr overwrites and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    w_any  = 1'b0;
    w_win  = 2'd0;
    w_scan = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_scan = r_ptr + 2'(k);
      if (bus.req[w_scan]) begin
        w_any = 1'b1;
        w_win = w_scan;
      end
    end
  end

  // Grant only when S1 can take it; held off while reset is asserted.
  assign w_gnt   = (w_any && w_acc1 && !reset) ? (4'b0001 << w_win) : 4'b0000;
  assign bus.gnt = w_gnt;

  // Operand mux for the winning requester
  always_comb begin
    w_sel_a = bus.a0;
    w_sel_b = bus.b0;
    case (w_win)
      2'd1:    begin w_sel_a = bus.a1; w_sel_b = bus.b1; end
      2'd2:    begin w_sel_a = bus.a2; w_sel_b = bus.b2; end
      2'd3:    begin w_sel_a = bus.a3; w_sel_b = bus.b3; end
      default: begin w_sel_a = bus.a0; w_sel_b = bus.b0; end
    endcase
  end

  // Full-width unsigned product, 0..225
  assign w_prod = {4'd0, r_s1_a} * {4'd0, r_s1_b};

`ifdef BCD_MUL_ARB_DIGIT_CHECK_EN
  assign w_bad = (r_s1_a > 4'd9) || (r_s1_b > 4'd9);
  assign w_y   = w_bad ? 8'd0 : w_prod;
`else
  assign w_bad = 1'b0;
  assign w_y   = w_prod;
`endif

  // Stage 1 capture and pointer update on grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 4'd0;
      r_s1_b     <= 4'd0;
      r_s1_id    <= 2'd0;
      r_ptr      <= 2'd3;
    end else if (w_acc1) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      if (w_gnt != 4'b0000) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_sel_a;
        r_s1_b     <= w_sel_b;
        r_s1_id    <= w_win;
        r_ptr      <= w_win;
      end else begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 output register, holds while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_y     <= 8'd0;
      r_out_id    <= 2'd0;
      r_out_err   <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_out_y     <= w_y;
      r_out_id    <= r_s1_id;
      r_out_err   <= w_bad;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_id    = r_out_id;
  assign bus.out_err   = r_out_err;

endmodule
